// File: rtl/nco_bank.sv
// nco_bank: bank of CHANNELS independent phase-accumulator oscillators with phase-continuous retuning.
// Latency: out/tick reflect the accumulator state registered on the previous clk edge; a retune takes effect on the channel's next wrap.
// Backpressure: wr_ready drops for a channel while it holds an unapplied update; writes to channel indices >= CHANNELS are always accepted and dropped.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       synchronous, active-low reset
//   enable    global run; accumulators advance only while high
//   wr_valid  configuration write request (valid/ready handshake with wr_ready)
//   wr_ready  combinational; low while the addressed channel has an update pending
//   wr_chan   target channel index
//   wr_data   new frequency tuning word (step = ftw + 1)
//   wr_mode   new output mode: 0 = square (acc MSB), 1 = pulse (tick)
//   out       per-channel oscillator output
//   tick      per-channel registered one-cycle wrap pulse
//   sync      only with NCO_BANK_SYNC_EN defined: clears all accumulators and applies pending updates
//
// Optional feature macro: NCO_BANK_SYNC_EN (adds the sync input and its logic).

module nco_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_mode,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
`ifdef NCO_BANK_SYNC_EN
  ,
  input  logic                sync
`endif
);

  // Per-channel configuration: tuning word plus output mode (0 = square, 1 = pulse).
  typedef struct packed {
    logic [WIDTH-1:0] ftw;
    logic             mode;
  } cfg_t;

  cfg_t                act_q  [CHANNELS];  // configuration currently driving the accumulator
  cfg_t                shd_q  [CHANNELS];  // staged configuration waiting for the next wrap
  logic [WIDTH-1:0]    acc_q  [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] tick_q;

  logic [WIDTH:0]      sum_w  [CHANNELS];  // acc + ftw + 1 with carry in the top bit
  logic [CHANNELS-1:0] wr_hit;             // accepted write lands on this channel
  logic [CHANNELS-1:0] apply_w;            // shadow -> active transfer on this edge
  logic                sync_w;
  cfg_t                wr_cfg;

`ifdef NCO_BANK_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  assign wr_cfg = '{ftw: wr_data, mode: wr_mode};

  // Ready is per addressed channel. Indices with no channel behind them
  // default to ready so that stray writes never stall the writer.
  always_comb begin
    wr_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_chan == CW'(c)) begin
        wr_ready = !pend_q[c];
      end
    end
  end

  // The addition always uses the active (old) ftw, so the edge that wraps
  // with the old step is also the edge that switches to the new step: the
  // new frequency starts exactly at phase zero-crossing, with no phase jump.
  // A paused channel has no wrap to wait for, so its update applies at once.
  always_comb begin
    wr_hit  = '0;
    apply_w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_w[c]   = {1'b0, acc_q[c]} + {1'b0, act_q[c].ftw} + {{WIDTH{1'b0}}, 1'b1};
      wr_hit[c]  = wr_valid && wr_ready && (wr_chan == CW'(c));
      apply_w[c] = pend_q[c] && (sync_w || !enable || sum_w[c][WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        act_q[c] <= '0;
        shd_q[c] <= '0;
      end
      pend_q <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // Sync overrides both the run gate and any carry on this edge.
        if (sync_w) begin
          acc_q[c]  <= '0;
          tick_q[c] <= 1'b0;
        end else if (enable) begin
          acc_q[c]  <= sum_w[c][WIDTH-1:0];
          tick_q[c] <= sum_w[c][WIDTH];
        end else begin
          tick_q[c] <= 1'b0;
        end

        if (apply_w[c]) begin
          act_q[c] <= shd_q[c];
        end

        // wr_hit needs pend_q low and apply_w needs it high, so they never
        // coincide. A write landing on a wrap edge therefore stays pending
        // until the following wrap.
        if (wr_hit[c]) begin
          shd_q[c]  <= wr_cfg;
          pend_q[c] <= 1'b1;
        end else if (apply_w[c]) begin
          pend_q[c] <= 1'b0;
        end
      end
    end
  end

  // Square mode shows the phase MSB; pulse mode shows the wrap strobe.
  always_comb begin
    out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out[c] = act_q[c].mode ? tick_q[c] : acc_q[c][WIDTH-1];
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_nco_bank.sv
// Directed self-checking bench for nco_bank at CHANNELS=4, WIDTH=8.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.

module tb_nco_bank;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_chan;
  logic [W-1:0]  wr_data;
  logic          wr_mode;
  logic [CH-1:0] out;
  logic [CH-1:0] tick;
`ifdef NCO_BANK_SYNC_EN
  logic          sync;
`endif

  nco_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .wr_mode  (wr_mode),
    .out      (out),
    .tick     (tick)
`ifdef NCO_BANK_SYNC_EN
    ,
    .sync     (sync)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic          en;
    logic          wv;
    logic [1:0]    ch;
    logic [W-1:0]  data;
    logic          mode;
    logic          exp_rdy;   // wr_ready before the edge
    logic [CH-1:0] exp_out;   // after the edge
    logic [CH-1:0] exp_tick;  // after the edge
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  int rise_k, fall_k, t1_k, t2_k, tcnt;
  int rdy_n, t2_first, t2_last, t2_cnt, t3_first, t3_cnt;
  int out128, first_tick, first_tick_val;

  initial begin
    // ch1 pulse-mode retune while paused, then write-on-wrap, then ch0 retune while paused.
    tbl[0]  = '{1'b0, 1'b1, 2'd1, 8'd127, 1'b1, 1'b1, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 2'd1, 8'd0,   1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0010, 4'b0010};
    tbl[4]  = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0010, 4'b0010};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b1, 1'b1, 2'd1, 8'd255, 1'b0, 1'b1, 4'b0010, 4'b0010};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[10] = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b0, 4'b0000, 4'b0010};
    tbl[11] = '{1'b1, 1'b0, 2'd1, 8'd0,   1'b0, 1'b1, 4'b0000, 4'b0010};
    tbl[12] = '{1'b0, 1'b1, 2'd0, 8'd255, 1'b1, 1'b1, 4'b0000, 4'b0000};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 8'd0,   1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'd0,   1'b0, 1'b1, 4'b0001, 4'b0011};

    rst      = 1'b0;
    enable   = 1'b1;
    wr_valid = 1'b1;
    wr_chan  = 2'd0;
    wr_data  = 8'd77;
    wr_mode  = 1'b1;
`ifdef NCO_BANK_SYNC_EN
    sync     = 1'b0;
`endif

    // Reset wins over enable and wr_valid.
    step();
    step();
    check("rst_out", int'(out), 0);
    check("rst_tick", int'(tick), 0);
    wr_valid = 1'b0;
    #1;
    check("rst_ready", int'(wr_ready), 1);

    // Square wave on ch0 with ftw=0: 128 low, 128 high, one tick per 256.
    rst = 1'b1;
    rise_k = -1; fall_k = -1; t1_k = -1; t2_k = -1; tcnt = 0;
    for (int k = 1; k <= 520; k++) begin
      step();
      if (out[0] && rise_k < 0) rise_k = k;
      if (!out[0] && rise_k >= 0 && fall_k < 0) fall_k = k;
      if (tick[0]) begin
        tcnt++;
        if (t1_k < 0) t1_k = k;
        else if (t2_k < 0) t2_k = k;
      end
    end
    check("sq_rise", rise_k, 128);
    check("sq_fall", fall_k, 256);
    check("sq_tick1", t1_k, 256);
    check("sq_tick2", t2_k, 512);
    check("sq_tick_cnt", tcnt, 2);

    // Table-driven vectors from a fresh reset with the bank paused.
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < NV; i++) begin
      enable   = tbl[i].en;
      wr_valid = tbl[i].wv;
      wr_chan  = tbl[i].ch;
      wr_data  = tbl[i].data;
      wr_mode  = tbl[i].mode;
      #1;
      check($sformatf("v%0d_ready", i), int'(wr_ready), int'(tbl[i].exp_rdy));
      step();
      check($sformatf("v%0d_out", i), int'(out), int'(tbl[i].exp_out));
      check($sformatf("v%0d_tick", i), int'(tick), int'(tbl[i].exp_tick));
    end
    wr_valid = 1'b0;

    // ch2 at acc=10, retune to ftw=63; ch2 blocked while pending, ch3 not.
    enable = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) step();
    rdy_n = -1; t2_first = -1; t2_last = -1; t2_cnt = 0; t3_first = -1; t3_cnt = 0;
    for (int n = 1; n <= 260; n++) begin
      wr_valid = 1'b0;
      wr_chan  = 2'd2;
      wr_data  = 8'd0;
      wr_mode  = 1'b0;
      if (n == 1) begin
        wr_valid = 1'b1; wr_data = 8'd63;
      end else if (n == 100) begin
        wr_valid = 1'b1; wr_data = 8'd200; wr_mode = 1'b1;
      end else if (n == 101) begin
        wr_valid = 1'b1; wr_chan = 2'd3; wr_data = 8'd255; wr_mode = 1'b1;
      end
      #1;
      if (n == 1)   check("rt_accept_ready", int'(wr_ready), 1);
      if (n == 100) check("rt_blocked_ready", int'(wr_ready), 0);
      if (n == 101) check("rt_other_ready", int'(wr_ready), 1);
      if (n > 1 && wr_chan == 2'd2 && wr_ready && rdy_n < 0) rdy_n = n - 1;
      step();
      if (tick[2]) begin
        t2_cnt++;
        t2_last = n;
        if (t2_first < 0) t2_first = n;
      end
      if (tick[3]) begin
        t3_cnt++;
        if (t3_first < 0) t3_first = n;
      end
    end
    wr_valid = 1'b0;
    check("rt_ready_back", rdy_n, 246);
    check("rt_t2_first", t2_first, 246);
    check("rt_t2_last", t2_last, 258);
    check("rt_t2_cnt", t2_cnt, 4);
    check("rt_t3_first", t3_first, 246);
    check("rt_t3_cnt", t3_cnt, 15);
    check("rt_out3_pulse", int'(out[3]), 1);

    // Reset mid-run with an update pending on ch0.
    wr_valid = 1'b1; wr_chan = 2'd0; wr_data = 8'd10; wr_mode = 1'b1;
    #1;
    check("mr_wr_ready", int'(wr_ready), 1);
    step();
    wr_valid = 1'b0;
    #1;
    check("mr_pending", int'(wr_ready), 0);
    rst = 1'b0; wr_valid = 1'b1; wr_chan = 2'd1; wr_data = 8'd99;
    step();
    check("mr_out", int'(out), 0);
    check("mr_tick", int'(tick), 0);
    wr_valid = 1'b0; wr_chan = 2'd0;
    #1;
    check("mr_ready0", int'(wr_ready), 1);
    wr_chan = 2'd1;
    #1;
    check("mr_ready1", int'(wr_ready), 1);
    rst = 1'b1;
    out128 = -1; first_tick = -1; first_tick_val = -1;
    for (int k = 1; k <= 260; k++) begin
      step();
      if (k == 128) out128 = int'(out);
      if (tick != '0 && first_tick < 0) begin
        first_tick = k;
        first_tick_val = int'(tick);
      end
    end
    check("mr_out128", out128, 15);
    check("mr_first_tick", first_tick, 256);
    check("mr_first_tick_val", first_tick_val, 15);

`ifdef NCO_BANK_SYNC_EN
    // Sync on ch0's wrap edge beats the carry and applies ch1's pending update.
    do_reset();
    enable = 1'b1;
    wr_valid = 1'b1; wr_chan = 2'd1; wr_data = 8'd127; wr_mode = 1'b1;
    step();
    wr_valid = 1'b0;
    for (int k = 2; k <= 255; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sy_tick", int'(tick), 0);
    check("sy_out", int'(out), 0);
    #1;
    check("sy_ready1", int'(wr_ready), 1);
    step();
    check("sy_tick_a", int'(tick), 0);
    step();
    check("sy_tick_b", int'(tick), 2);
    check("sy_out_b", int'(out), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nco_bank.md
NCO_BANK -- requirements
Module: nco_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent oscillator channels, legal range 1..16.
REQ-002 Parameter WIDTH, default 8: phase accumulator and tuning word width in bits, legal range 4..32.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-low.
REQ-005 Port enable  input  1: global run; accumulators advance only while high.
REQ-006 Port wr_valid  input  1: configuration write request.
REQ-007 Port wr_ready  output  1: write accepted on the edge where wr_valid and wr_ready are both high.
REQ-008 Port wr_chan  input  max(1,clog2(CHANNELS)): target channel index.
REQ-009 Port wr_data  input  WIDTH: new tuning word (ftw).
REQ-010 Port wr_mode  input  1: new output mode; 0 = square, 1 = pulse.
REQ-011 Port out  output  CHANNELS: per-channel oscillator output.
REQ-012 Port tick  output  CHANNELS: per-channel registered one-cycle wrap pulse.

Function
REQ-013 Each channel SHALL hold an active ftw, an active mode, an unsigned WIDTH-bit accumulator acc, a shadow ftw/mode and a pending flag.
REQ-014 On each edge with enable high, each channel SHALL compute acc + ftw + 1 at WIDTH+1 bits, store the low WIDTH bits in acc and register the carry bit into tick[c]; with enable low, acc holds and tick[c] is 0.
REQ-015 out[c] SHALL equal acc[WIDTH-1] in square mode and tick[c] in pulse mode.
REQ-016 Output period SHALL be 2^WIDTH / (ftw+1) cycles; ftw = 0 still advances by 1, and ftw = 2^WIDTH-1 wraps every cycle.
REQ-017 wr_ready SHALL be the combinational value !pending[wr_chan], or 1 when wr_chan >= CHANNELS.
REQ-018 An accepted write SHALL load shadow ftw/mode and set pending for that channel; a write to a channel index >= CHANNELS SHALL be accepted and discarded.
REQ-019 A pending channel SHALL use its old ftw for the addition that produces a carry, load active ftw/mode from the shadow on that same edge and clear pending; this gives phase-continuous retuning.
REQ-020 With enable low, a pending update SHALL apply on the next edge.
REQ-021 A write accepted on the same edge as a carry of that channel SHALL remain pending until the following carry.
REQ-022 All channels SHALL be fully independent; simultaneous carries on several channels SHALL all be handled on the same edge.

Reset
REQ-023 On an edge with rst low, the block SHALL set acc, active ftw, shadow ftw, pending, tick and out to 0 and set all modes to square; this applies regardless of enable or wr_valid.
REQ-024 Reset asserted mid-period SHALL discard pending updates, and the first carry after release SHALL occur after exactly 2^WIDTH/(ftw+1) enabled cycles from 0.

Configuration
REQ-025 With macro NCO_BANK_SYNC_EN defined, the block SHALL provide input port sync (1 bit) that, on an edge where it is high, clears every acc to 0, forces tick to 0, and applies all pending updates.
REQ-026 Sync SHALL act whether or not enable is high and SHALL win over a simultaneous carry.
REQ-027 Without NCO_BANK_SYNC_EN, the sync port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (WIDTH=8, CHANNELS=4)
REQ-028 Reset, then enable=1 with ftw=0 on ch0 in square mode -> out[0] low for 128 cycles and high for 128 cycles; tick[0] pulses once every 256 cycles.
REQ-029 Write ftw=127 with mode=1 to ch1 while enable=0, then enable=1 -> update applies on the next edge, and out[1]=tick[1] pulses every 2nd cycle.
REQ-030 Ch2 running with ftw=0 and acc=10; write ftw=63 -> wr_ready for ch2 stays 0 until the wrap 246 cycles later; the step then becomes 64 and tick[2] fires every 4 cycles.
REQ-031 Write to wr_chan=2 while ch2 is pending -> wr_ready=0, and the write is not accepted until pending clears; a simultaneous write to ch3 is accepted.
REQ-032 Pull rst low mid-run with an update pending -> next cycle all out, tick and acc are 0 and pending is cleared; after release with ftw=0, the first tick occurs at 256 enabled cycles.
REQ-033 With NCO_BANK_SYNC_EN, assert sync on a carry cycle of ch0 -> tick[0] stays 0 and all acc read 0; without the macro the bench confirms the sync port is absent.
